gated_edge_counter: RTL and testbench

- Upstream stage of the 40-bit normalising shifter.
- Counts rising edges of an external signal over a programmable gate window of clk cycles.
- At the end of each window, latches the count onto a CNT_W-bit bus that drives the shifter's 40-bit input.
- Runs single-shot on a start pulse, or back-to-back while continuous mode is held.

---
 rtl/gated_edge_counter.sv | 139 +++++++++++++
 tb/tb_gated_edge_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gated_edge_counter.sv
// Gated rising-edge counter feeding the 40-bit normalising shifter.
// Counts sig_in rising edges over a window of max(gate_len,1) clk cycles and latches
// the saturating count onto count_out at the end of each window. It runs single-shot on start,
// or back-to-back while continuous is held.
// Optional macro GEC_INPUT_SYNC_EN inserts a 2-flop synchroniser on sig_in.
module gated_edge_counter #(
  parameter int unsigned CNT_W  = 40,
  parameter int unsigned GATE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StArm, StGate} state_e;

  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]  count_out_q, count_out_d;
  logic              overflow_q, overflow_d;
  logic              count_valid_q, count_valid_d;
  logic              sig_s;
  logic              sig_d_q;
  logic              edge_det;
  logic [CNT_W-1:0]  acc_inc;
  logic              ovf_inc;

`ifdef GEC_INPUT_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchroniser for an asynchronous sig_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

  assign sig_s = sync2_q;
`else
  assign sig_s = sig_in;
`endif

  // Delayed copy of the (synchronised) signal for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d_q <= 1'b0;
    end else begin
      sig_d_q <= sig_s;
    end
  end

  assign edge_det = sig_s & ~sig_d_q;

  // Saturating increment; hitting all-ones marks the window as overflowed.
  always_comb begin
    acc_inc = acc_q;
    if (edge_det && !(&acc_q)) begin
      acc_inc = acc_q + 1'b1;
    end
    ovf_inc = ovf_acc_q | (edge_det & (&acc_inc));
  end

  // Window sequencing and result capture.
  always_comb begin
    state_d       = state_q;
    gate_cnt_d    = gate_cnt_q;
    acc_d         = acc_q;
    ovf_acc_d     = ovf_acc_q;
    count_out_d   = count_out_q;
    overflow_d    = overflow_q;
    count_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start || continuous) begin
          state_d = StArm;
        end
      end
      StArm: begin
        // A zero length still gives a one-cycle window.
        gate_cnt_d = (gate_len == '0) ? GATE_W'(1) : gate_len;
        acc_d      = '0;
        ovf_acc_d  = 1'b0;
        state_d    = StGate;
      end
      StGate: begin
        acc_d      = acc_inc;
        ovf_acc_d  = ovf_inc;
        gate_cnt_d = gate_cnt_q - 1'b1;
        if (gate_cnt_q == GATE_W'(1)) begin
          count_out_d   = acc_inc;
          overflow_d    = ovf_inc;
          count_valid_d = 1'b1;
          state_d       = continuous ? StArm : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      gate_cnt_q    <= '0;
      acc_q         <= '0;
      ovf_acc_q     <= 1'b0;
      count_out_q   <= '0;
      overflow_q    <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_cnt_q    <= gate_cnt_d;
      acc_q         <= acc_d;
      ovf_acc_q     <= ovf_acc_d;
      count_out_q   <= count_out_d;
      overflow_q    <= overflow_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_gated_edge_counter.sv
// Bench for gated_edge_counter: a 40-bit and an 8-bit instance share all stimulus.
// A window-level model (integer edge count per window, clamped per width) is
// compared with both instances every cycle; directed literal checks pin the model.
module tb_gated_edge_counter;
  localparam int unsigned GATE_W = 32;
`ifdef GEC_INPUT_SYNC_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif
  localparam longint MAX40 = 64'h0000_00FF_FFFF_FFFF;
  localparam longint MAX8  = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic              sig_in;
  logic              start;
  logic              continuous;
  logic [GATE_W-1:0] gate_len;
  logic [39:0]       cnt40;
  logic              v40, o40, b40;
  logic [7:0]        cnt8;
  logic              v8, o8, b8;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int sig_period = 0;
  int ph_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  gated_edge_counter #(.CNT_W(40), .GATE_W(GATE_W)) u_dut40 (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .gate_len   (gate_len),
    .count_out  (cnt40),
    .count_valid(v40),
    .overflow   (o40),
    .busy       (b40)
  );

  gated_edge_counter #(.CNT_W(8), .GATE_W(GATE_W)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .gate_len   (gate_len),
    .count_out  (cnt8),
    .count_valid(v8),
    .overflow   (o8),
    .busy       (b8)
  );

  // Window model: 0 idle, 1 dead cycle before a window, 2 inside a window.
  int     m_ph = 0;
  longint m_rem = 0;
  longint m_acc = 0;
  longint m_last = 0;
  logic   m_valid = 1'b0;
  logic   m_prev = 1'b0;
  logic   m_s1 = 1'b0;
  logic   m_s2 = 1'b0;

  always @(posedge clk) begin : model
    logic s, e;
    s = (LAG != 0) ? m_s2 : sig_in;
    e = s & ~m_prev;
    if (rst) begin
      m_ph = 0; m_rem = 0; m_acc = 0; m_last = 0; m_valid = 1'b0;
      m_prev = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_valid = 1'b0;
      case (m_ph)
        0: if (start || continuous) m_ph = 1;
        1: begin
          m_rem = (gate_len == 0) ? 1 : longint'(gate_len);
          m_acc = 0;
          m_ph  = 2;
        end
        default: begin
          m_acc += longint'(e);
          if (m_rem == 1) begin
            m_last  = m_acc;
            m_valid = 1'b1;
            m_ph    = continuous ? 1 : 0;
          end else begin
            m_rem--;
          end
        end
      endcase
      m_prev = s;
      m_s2   = m_s1;
      m_s1   = sig_in;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    longint e8;
    e8 = (m_last > MAX8) ? MAX8 : m_last;
    chk("count_out40", longint'(cnt40), m_last);
    chk("overflow40", longint'(o40), longint'(m_last >= MAX40));
    chk("valid40", longint'(v40), longint'(m_valid));
    chk("busy40", longint'(b40), longint'(m_ph != 0));
    chk("count_out8", longint'(cnt8), e8);
    chk("overflow8", longint'(o8), longint'(m_last >= MAX8));
    chk("valid8", longint'(v8), longint'(m_valid));
    chk("busy8", longint'(b8), longint'(m_ph != 0));
    if (v40) n_pulses++;
  endtask

  // One clock: compare on the falling edge, then drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (sig_period != 0) begin
      ph_cnt++;
      sig_in = (ph_cnt % sig_period) < (sig_period / 2);
    end
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!v40 && lat < limit);
    if (!v40) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_valid: no count_valid within %0d cycles", limit);
    end
  endtask

  task automatic set_period(input int p);
    sig_period = p;
    ph_cnt     = 0;
    if (p == 0) sig_in = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int lat, p0;
    rst = 1'b1; sig_in = 1'b0; start = 1'b0; continuous = 1'b0; gate_len = '0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Idle with toggling input: nothing happens.
    sig_period = 2;
    repeat (20) tick();
    chk("idle_count", longint'(cnt40), 0);
    chk("idle_pulses", longint'(n_pulses), 0);
    chk("idle_busy", longint'(b40), 0);

    // Single shot, 100-cycle window, period 4.
    set_period(4);
    gate_len = 100;
    start = 1'b1;
    wait_valid(200, lat);
    chk("single_latency", longint'(lat), 102);
    chk("single_count", longint'(cnt40), 25);
    chk("single_ovf", longint'(o40), 0);
    chk("model_single", m_last, 25);
    tick();
    chk("single_busy_after", longint'(b40), 0);

    // Continuous windows of 40, period 8.
    set_period(8);
    gate_len   = 40;
    continuous = 1'b1;
    wait_valid(100, lat);
    chk("cont_first_lat", longint'(lat), 42);
    chk("cont_first_cnt", longint'(cnt40), 5);
    for (int i = 0; i < 3; i++) begin
      wait_valid(100, lat);
      chk("cont_spacing", longint'(lat), 41);
      chk("cont_cnt", longint'(cnt40), 5);
    end
    repeat (20) tick();
    continuous = 1'b0;
    wait_valid(100, lat);
    chk("cont_drop_lat", longint'(lat), 21);
    chk("cont_drop_cnt", longint'(cnt40), 5);
    repeat (5) tick();
    chk("cont_drop_idle", longint'(b40), 0);

    // Zero gate length: one-cycle window catching a single rise.
    set_period(0);
    gate_len = 0;
    start = 1'b1;
    repeat (2 - LAG) tick();
    sig_in = 1'b1;
    wait_valid(20, lat);
    chk("zero_len_lat", longint'(lat), longint'(1 + LAG));
    chk("zero_len_cnt", longint'(cnt40), 1);
    chk("model_zero_len", m_last, 1);

    // Reset in the 50th cycle of a 100-cycle window.
    set_period(4);
    gate_len = 100;
    p0 = n_pulses;
    start = 1'b1;
    repeat (51) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", longint'(cnt40), 0);
    chk("rst_valid", longint'(v40), 0);
    chk("rst_ovf", longint'(o40), 0);
    chk("rst_busy", longint'(b40), 0);
    repeat (10) tick();
    chk("rst_no_pulse", longint'(n_pulses - p0), 0);

    // Fresh window after reset, with a start pulse while busy.
    p0 = n_pulses;
    start = 1'b1;
    repeat (30) tick();
    start = 1'b1;
    wait_valid(200, lat);
    chk("busy_start_lat", longint'(lat), 72);
    chk("fresh_count", longint'(cnt40), 25);
    repeat (120) tick();
    chk("busy_start_pulses", longint'(n_pulses - p0), 1);

    // Saturation on the 8-bit instance: 300 rises over 600 cycles.
    set_period(2);
    gate_len = 600;
    start = 1'b1;
    wait_valid(700, lat);
    chk("sat_lat", longint'(lat), 602);
    chk("sat_cnt8", longint'(cnt8), 255);
    chk("sat_ovf8", longint'(o8), 1);
    chk("sat_cnt40", longint'(cnt40), 300);
    chk("sat_ovf40", longint'(o40), 0);

    // Quiet window clears the count and overflow.
    set_period(0);
    gate_len = 10;
    start = 1'b1;
    wait_valid(50, lat);
    chk("quiet_cnt8", longint'(cnt8), 0);
    chk("quiet_ovf8", longint'(o8), 0);
    chk("quiet_cnt40", longint'(cnt40), 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
